// File: rtl/rv32i_pkg.sv
// Shared RV32I write-back constants and types: register file geometry,
// completion source identifiers and the completion request bundle.
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  // Enum value doubles as the requester index inside the arbiter.
  typedef enum logic [0:0] {
    WB_SRC_LD  = 1'b0,
    WB_SRC_ALU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue, completion and regfile-write signals around the write-back scoreboard.
// Bypass outputs exist only when WB_BYPASS_EN is defined.
interface wb_scoreboard_if;

  logic                           issue_valid;
  logic [rv32i_pkg::REG_AW-1:0]   issue_rd;
  logic [rv32i_pkg::REG_AW-1:0]   issue_rs1;
  logic [rv32i_pkg::REG_AW-1:0]   issue_rs2;
  logic                           issue_uses_rs1;
  logic                           issue_uses_rs2;
  logic                           issue_has_rd;
  logic                           issue_ready;

  logic                           alu_valid;
  logic [rv32i_pkg::REG_AW-1:0]   alu_rd;
  logic [rv32i_pkg::XLEN-1:0]     alu_data;
  logic                           alu_ready;

  logic                           ld_valid;
  logic [rv32i_pkg::REG_AW-1:0]   ld_rd;
  logic [rv32i_pkg::XLEN-1:0]     ld_data;
  logic                           ld_ready;

  logic                           rf_we;
  logic [rv32i_pkg::REG_AW-1:0]   rf_rd_addr;
  logic [rv32i_pkg::XLEN-1:0]     rf_rd_data;
  logic [rv32i_pkg::NUM_REGS-1:0] busy;
  logic                           err;

`ifdef WB_BYPASS_EN
  logic                           byp_rs1_hit;
  logic                           byp_rs2_hit;
  logic [rv32i_pkg::XLEN-1:0]     byp_data;
`endif

  modport master (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
           issue_uses_rs1, issue_uses_rs2, issue_has_rd,
           alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
`ifdef WB_BYPASS_EN
    output byp_rs1_hit, byp_rs2_hit, byp_data,
`endif
    output issue_ready, alu_ready, ld_ready,
           rf_we, rf_rd_addr, rf_rd_data, busy, err
  );

  modport slave (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
           issue_uses_rs1, issue_uses_rs2, issue_has_rd,
           alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
`ifdef WB_BYPASS_EN
    input  byp_rs1_hit, byp_rs2_hit, byp_data,
`endif
    input  issue_ready, alu_ready, ld_ready,
           rf_we, rf_rd_addr, rf_rd_data, busy, err
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// N-way round-robin arbiter: the search starts just after the last granted
// requester; the pointer moves only when something is granted.
module wb_rr_arbiter #(
  parameter int N          = 2,
  parameter int RESET_LAST = N - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic          found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        last_d     = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(RESET_LAST);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/wb_scoreboard.sv
// RV32I write-back initiator: busy scoreboard, RAW/WAW issue gating and
// round-robin completion arbitration onto the regfile write port.
// Optional: define WB_BYPASS_EN to forward the write stage into the RAW check.
module wb_scoreboard
  import rv32i_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_scoreboard_if.master  bus
);

  localparam int NSRC = 2;

  logic [NSRC-1:0]     req;
  logic [NSRC-1:0]     grant;
  wb_req_t             ld_req;
  wb_req_t             alu_req;
  wb_req_t             win;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] raw_busy;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_rd_addr_q;
  logic [XLEN-1:0]     rf_rd_data_q;
  logic                err_q;
  logic                hazard;
  logic                issue_fire;

  assign req[WB_SRC_LD]  = bus.ld_valid;
  assign req[WB_SRC_ALU] = bus.alu_valid;

  wb_rr_arbiter #(.N(NSRC), .RESET_LAST(int'(WB_SRC_ALU))) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  assign bus.ld_ready  = grant[WB_SRC_LD];
  assign bus.alu_ready = grant[WB_SRC_ALU];

  // With no grant neither source is valid, so win.valid marks the handshake.
  always_comb begin
    ld_req  = '{valid: bus.ld_valid,  rd: bus.ld_rd,  data: bus.ld_data};
    alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
    win     = grant[WB_SRC_ALU] ? alu_req : ld_req;
  end

  always_comb begin
    raw_busy = busy_q;
`ifdef WB_BYPASS_EN
    if (rf_we_q) raw_busy[rf_rd_addr_q] = 1'b0;
`endif
    hazard = (bus.issue_uses_rs1 && raw_busy[bus.issue_rs1]) ||
             (bus.issue_uses_rs2 && raw_busy[bus.issue_rs2]) ||
             (bus.issue_has_rd   && busy_q[bus.issue_rd]);
    issue_fire = bus.issue_valid && !hazard && bus.issue_has_rd &&
                 (bus.issue_rd != '0);
  end

  assign bus.issue_ready = !hazard;

  // Clear on commit, then set on issue, so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q)    busy_d[rf_rd_addr_q] = 1'b0;
    if (issue_fire) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_rd_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= win.valid && (win.rd != '0);
      if (win.valid) begin
        rf_rd_addr_q <= win.rd;
        rf_rd_data_q <= win.data;
        if ((win.rd != '0) && !busy_q[win.rd]) err_q <= 1'b1;
      end
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd_addr = rf_rd_addr_q;
  assign bus.rf_rd_data = rf_rd_data_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

`ifdef WB_BYPASS_EN
  assign bus.byp_rs1_hit = bus.issue_uses_rs1 && rf_we_q && (rf_rd_addr_q == bus.issue_rs1);
  assign bus.byp_rs2_hit = bus.issue_uses_rs2 && rf_we_q && (rf_rd_addr_q == bus.issue_rs2);
  assign bus.byp_data    = rf_rd_data_q;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard: reset, hazards, arbitration,
// x0 handling, sticky err and mid-write reset (bypass step when WB_BYPASS_EN).
module tb_wb_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_scoreboard_if bus ();

  wb_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_issue();
    bus.issue_valid    = 1'b0;
    bus.issue_rd       = '0;
    bus.issue_rs1      = '0;
    bus.issue_rs2      = '0;
    bus.issue_uses_rs1 = 1'b0;
    bus.issue_uses_rs2 = 1'b0;
    bus.issue_has_rd   = 1'b0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle_issue();
    bus.issue_valid  = 1'b1;
    bus.issue_rd     = rd;
    bus.issue_has_rd = 1'b1;
    #1;
    check("issue_rd_ready", 32'(bus.issue_ready), 32'd1);
    tick();
    idle_issue();
  endtask

  initial begin
    rst = 1'b1;
    idle_issue();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    tick(); tick();
    check("rst_busy",  bus.busy, 32'h0);
    check("rst_we",    32'(bus.rf_we), 32'd0);
    check("rst_addr",  32'(bus.rf_rd_addr), 32'd0);
    check("rst_data",  bus.rf_rd_data, 32'h0);
    check("rst_err",   32'(bus.err), 32'd0);
    rst = 1'b0;

    // Issue rd=5, then a reader of x5 is blocked.
    issue_rd(5'd5);
    check("t1_busy5", bus.busy, 32'h0000_0020);
    bus.issue_valid = 1'b1; bus.issue_uses_rs1 = 1'b1; bus.issue_rs1 = 5'd5;
    #1;
    check("t1_raw_block", 32'(bus.issue_ready), 32'd0);

    // ALU completes rd=5; write stage next cycle; x5 readable after that.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    check("t2_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("t2_ld_ready",  32'(bus.ld_ready),  32'd0);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("t2_we",   32'(bus.rf_we), 32'd1);
    check("t2_addr", 32'(bus.rf_rd_addr), 32'd5);
    check("t2_data", bus.rf_rd_data, 32'hDEAD_BEEF);
    check("t2_busy_held", bus.busy, 32'h0000_0020);
`ifdef WB_BYPASS_EN
    check("t2_ready_wstage", 32'(bus.issue_ready), 32'd1);
`else
    check("t2_ready_wstage", 32'(bus.issue_ready), 32'd0);
`endif
    tick();
    check("t2_we_off",  32'(bus.rf_we), 32'd0);
    check("t2_busy_clr", bus.busy, 32'h0);
    check("t2_ready",   32'(bus.issue_ready), 32'd1);
    check("t2_err",     32'(bus.err), 32'd0);
    idle_issue();

    // Fresh reset so load holds the round-robin priority.
    rst = 1'b1; tick(); rst = 1'b0;
    issue_rd(5'd7); issue_rd(5'd8); issue_rd(5'd10);
    check("t3_busy", bus.busy, 32'h0000_0580);
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd7; bus.ld_data  = 32'h1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h2;
    #1;
    check("t3_a_ld_ready",  32'(bus.ld_ready),  32'd1);
    check("t3_a_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.ld_rd = 5'd10; bus.ld_data = 32'h3;
    #1;
    check("t3_b_ld_ready",  32'(bus.ld_ready),  32'd0);
    check("t3_b_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("t3_b_we",   32'(bus.rf_we), 32'd1);
    check("t3_b_addr", 32'(bus.rf_rd_addr), 32'd7);
    check("t3_b_data", bus.rf_rd_data, 32'h1);
    tick();
    bus.alu_valid = 1'b0;
    #1;
    check("t3_c_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("t3_c_addr", 32'(bus.rf_rd_addr), 32'd8);
    check("t3_c_data", bus.rf_rd_data, 32'h2);
    check("t3_c_busy", bus.busy, 32'h0000_0500);
    tick();
    bus.ld_valid = 1'b0;
    check("t3_d_addr", 32'(bus.rf_rd_addr), 32'd10);
    check("t3_d_data", bus.rf_rd_data, 32'h3);
    tick();
    check("t3_e_we",   32'(bus.rf_we), 32'd0);
    check("t3_e_busy", bus.busy, 32'h0);
    check("t3_e_err",  32'(bus.err), 32'd0);

    // x0: never busy, completion handshakes without a write.
    issue_rd(5'd0);
    check("t4_x0_busy", bus.busy, 32'h0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
    #1;
    check("t4_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("t4_we",   32'(bus.rf_we), 32'd0);
    check("t4_busy", bus.busy, 32'h0);
    check("t4_err",  32'(bus.err), 32'd0);

    // Completion to a non-busy register: write still happens, err sticks.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    check("t5_we",   32'(bus.rf_we), 32'd1);
    check("t5_addr", 32'(bus.rf_rd_addr), 32'd9);
    check("t5_data", bus.rf_rd_data, 32'h99);
    check("t5_err",  32'(bus.err), 32'd1);
    tick();
    check("t5_err_sticky", 32'(bus.err), 32'd1);
    issue_rd(5'd4);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    tick();
    bus.alu_valid = 1'b0;
    check("t5_mid_we",   32'(bus.rf_we), 32'd1);
    check("t5_mid_busy", bus.busy, 32'h0000_0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_we",   32'(bus.rf_we), 32'd0);
    check("t5_rst_busy", bus.busy, 32'h0);
    check("t5_rst_err",  32'(bus.err), 32'd0);
    check("t5_rst_addr", 32'(bus.rf_rd_addr), 32'd0);

`ifdef WB_BYPASS_EN
    issue_rd(5'd3);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h55;
    tick();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_uses_rs2 = 1'b1; bus.issue_rs2 = 5'd3;
    #1;
    check("t6_busy3",  bus.busy, 32'h0000_0008);
    check("t6_ready",  32'(bus.issue_ready), 32'd1);
    check("t6_hit2",   32'(bus.byp_rs2_hit), 32'd1);
    check("t6_hit1",   32'(bus.byp_rs1_hit), 32'd0);
    check("t6_bdata",  bus.byp_data, 32'h55);
    tick();
    idle_issue();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
Write-back initiator for the RV32I register file. It arbitrates completed results from the ALU and the load unit onto the single regfile write port (we / rd_addr / rd_data). It keeps a 32-entry busy scoreboard of registers with writes in flight, and raises issue_ready only when the instruction in decode has no RAW or WAW hazard. It sits between decode/issue, the execution units and the register file.

Parameters:
XLEN, 32, data width of results and register contents
NUM_REGS, 32, architectural register count (x0 hardwired zero)
REG_AW, 5, register address width, equal to log2(NUM_REGS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
issue_valid  in  1  decode presents an instruction
issue_rd  in  REG_AW  destination register
issue_rs1  in  REG_AW  source 1
issue_rs2  in  REG_AW  source 2
issue_uses_rs1  in  1  instruction reads rs1
issue_uses_rs2  in  1  instruction reads rs2
issue_has_rd  in  1  instruction writes rd
issue_ready  out  1  no hazard; issue accepted when valid and ready
alu_valid  in  1  ALU result available
alu_rd  in  REG_AW  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle
ld_valid  in  1  load result available
ld_rd  in  REG_AW  load destination
ld_data  in  XLEN  load result
ld_ready  out  1  load result accepted this cycle
rf_we  out  1  regfile write enable
rf_rd_addr  out  REG_AW  regfile write address
rf_rd_data  out  XLEN  regfile write data
busy  out  NUM_REGS  scoreboard bits
err  out  1  sticky: completion to a register that is not busy

Behaviour:
- Reset: busy=0, rf_we=0, rf_rd_addr=0, rf_rd_data=0, err=0, round-robin pointer set to favour load. Reset mid-operation discards in-flight writes; rf_we is 0 the cycle after rst.
- busy[0] is constant 0.
- issue_ready is combinational. It is 0 if any of the following holds, otherwise 1:
  - RAW: issue_uses_rs1 and busy[issue_rs1]
  - RAW: issue_uses_rs2 and busy[issue_rs2]
  - WAW: issue_has_rd and busy[issue_rd]
- issue_ready does not depend on issue_valid.
- Issue fire (issue_valid and issue_ready and issue_has_rd and issue_rd≠0): busy[issue_rd] is set at that edge.
- Completion arbitration is combinational round-robin over {ld, alu}:
  - Only one valid: that source is granted.
  - Both valid: the source not granted last time is granted; the pointer updates only on a grant.
  - *_ready = grant.
- The write stage is one register. On a grant at edge N:
  - rf_we=1 during cycle N+1, with rf_rd_addr/rf_rd_data latched from the winner.
  - If the winner's rd=0: the handshake completes but rf_we stays 0.
- Busy clear: busy[rf_rd_addr] clears at the edge where rf_we=1, i.e. the same edge the regfile commits. The regfile read path therefore returns the new value from the following cycle. Total latency from handshake to readable is 2 cycles.
- Set and clear of the same index on the same edge: set wins. This cannot occur architecturally because WAW blocks the issue.
- Completion whose rd is not busy at the handshake edge: the write is still performed, busy is unchanged, and err is set sticky until rst.
- No result back-pressure beyond arbitration; the losing source holds valid and data stable.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - A register whose write sits in the rf_we stage (rf_we=1, addr match) does not count as busy for the RAW check.
  - Adds outputs byp_rs1_hit, byp_rs2_hit (1 bit each) and byp_data (XLEN, = rf_rd_data).
  - Decode muxes byp_data over the regfile read data when hit.
  - Issue-to-dependent latency drops by 1 cycle.
- Undefined: the bypass ports are absent and RAW uses raw busy bits.

Decomposition:
- Package rv32i_pkg holds:
  - XLEN, NUM_REGS, REG_AW constants
  - wb_src_e enum {WB_SRC_LD, WB_SRC_ALU}
  - wb_req_t struct {valid, rd, data}
- Sub-module wb_rr_arbiter: 2-way round-robin grant plus pointer flop, parameterised on requester count.

Test Plan:
1. Reset release, issue rd=5 (no sources) -> issue_ready=1; busy[5]=1 next cycle. Issue reading rs1=5 -> issue_ready=0.
2. ALU completes rd=5 data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, addr=5, data=0xDEADBEEF; cycle after, busy[5]=0 and the rs1=5 issue goes ready.
3. Both ld (rd=7, 0x1) and alu (rd=8, 0x2) valid for 2 cycles after reset -> load granted first, ALU second; rf writes 7 then 8 on consecutive cycles.
4. Completion to rd=0 data=0xFFFFFFFF -> ready=1, rf_we stays 0, busy unchanged, err=0.
5. ALU completion to rd=9 while busy[9]=0 -> write occurs, err=1 and remains 1 until rst. Assert rst mid-write -> rf_we=0, busy=0, err=0 next cycle.
6. With WB_BYPASS_EN, busy[3] with rf_we stage addr=3 data=0x55 -> issue rs2=3 ready in that cycle, byp_rs2_hit=1, byp_data=0x55.
